s_exp_bias_pipe: RTL and testbench
==================================

// Module: s_exp_bias_pipe
// PURPOSE
// - Downstream stage of the exponent adder in the float multiply path. Takes the raw biased-exponent sum, adds the mantissa
//   normalisation increment and removes one bias, then saturates and flags overflow/underflow.
// - 2-stage valid/ready pipeline with back-pressure; feeds the result packer. Sticky status flags are kept for the control FSM.
// PARAMETERS
// - W_EXP   8    width of one biased exponent field
// - BIAS    127  exponent bias removed from the sum (2^(W_EXP-1)-1)
// - W_SUM   10   width of the incoming exponent sum (W_EXP+2, i.e. sum of two 9-bit operands)
// PORTS
// - clk          in   1        system clock, all logic on rising edge
// - rst          in   1        synchronous reset, active-high
// - in_valid_i   in   1        sum_i/norm_inc_i valid
// - in_ready_o   out  1        stage can accept; transfer when in_valid_i & in_ready_o
// - sum_i        in   W_SUM    unsigned exponent sum from the adder
// - norm_inc_i   in   1        +1 from mantissa normalisation
// - out_valid_o  out  1        exp_o/ovf_o/unf_o valid
// - out_ready_i  in   1        consumer accepts; transfer when out_valid_o & out_ready_i
// - exp_o        out  W_EXP    final biased exponent, saturated
// - ovf_o        out  1        result overflowed (exp_o forced all-ones)
// - unf_o        out  1        result underflowed (exp_o forced zero)
// - clr_i        in   1        clears sticky flags
// - ovf_sticky_o out  1        set on any transferred-out ovf_o, held until clr_i
// - unf_sticky_o out  1        set on any transferred-out unf_o, held until clr_i
// BEHAVIOUR
// - Reset: s1/s2 valid=0, out_valid_o=0, exp_o=0, ovf_o=0, unf_o=0, both sticky=0; in_ready_o=1 the cycle after reset.
// - Stage 1 (on input transfer): e = $signed({0,sum_i}) + norm_inc_i - BIAS, held in W_SUM+2 signed bits; no wrap possible.
// - Stage 2 (on s1->s2 advance): if e >= 2^W_EXP-1: exp=all-ones, ovf=1, unf=0; elif e <= 0: exp=0, unf=1, ovf=0;
//   else exp=e[W_EXP-1:0], flags 0. Exactly one of ovf/unf may be 1. e = 2^W_EXP-1 exactly is overflow (reserved code).
// - Latency: 2 cycles input-transfer to out_valid_o with out_ready_i held 1; throughput 1/cycle.
// - Handshake: s2 loads when s2 empty or output transfers this cycle; s1 loads when s1 empty or s1 advances this cycle;
//   in_ready_o = ~s1_valid | s1_advance (combinational from out_ready_i, no loop through in_valid_i).
// - Back-pressure: out_ready_i=0 with both stages full -> in_ready_o=0, all data/flags held stable, no loss or duplication.
// - out_valid_o, once high, stays high with exp_o/ovf_o/unf_o unchanged until transfer.
// - Sticky: set on output transfer carrying the flag; clr_i clears; same-cycle clr_i and set -> set wins.
// - Reset mid-operation: in-flight items discarded, no output transfer occurs in the reset cycle.
// - in_valid_i low: stage bubbles propagate; data regs may hold stale values, only valids gate outputs.
// STRUCTURE
// - Shared package: W_EXP/BIAS defaults, exponent all-ones constant, flag-pair struct {ovf,unf}.
// - One sub-module natural: s_pipe_reg (generic valid/ready register slice, width param), instantiated twice;
//   arithmetic and saturation live in this module between the slices.
// TESTING (W_EXP=8, BIAS=127, W_SUM=10)
// - sum=254, inc=0, out_ready=1 -> 2 cycles later exp_o=127, ovf=0, unf=0, out_valid_o one cycle.
// - sum=381, inc=0 -> e=254, exp_o=254 no flag; sum=381, inc=1 -> e=255, exp_o=255, ovf_o=1, ovf_sticky_o=1.
// - sum=127, inc=0 -> e=0, exp_o=0, unf_o=1; sum=127, inc=1 -> exp_o=1, no flag; sum=0 -> unf_o=1.
// - Back-to-back 8 inputs, out_ready_i=0 for cycles 3-6 -> in_ready_o drops after 2 accepted, outputs in order, none lost.
// - clr_i asserted same cycle an ovf result transfers -> ovf_sticky_o remains 1; next clr_i alone -> 0.
// - rst pulsed with both stages full -> out_valid_o=0 next cycle, flags 0, first post-reset input emerges after 2 cycles.

Source files
------------

// File: rtl/s_exp_bias_pipe_pkg.sv
// Shared definitions for the exponent bias/saturation pipeline.
//   EXP_W_DEF / BIAS_DEF / SUM_W_DEF : default field widths and bias
//   exp_max()                        : largest biased exponent code for a width
//   EXP_ONES                         : all-ones exponent for the default width
//   flags_t                          : {ovf, unf} status pair carried with a result
package s_exp_bias_pipe_pkg;

    localparam int unsigned EXP_W_DEF = 8;
    localparam int unsigned BIAS_DEF  = 127;
    localparam int unsigned SUM_W_DEF = EXP_W_DEF + 2;

    // All-ones code of a w-bit exponent (reserved: inf/NaN).
    function automatic int unsigned exp_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam int unsigned EXP_ONES = exp_max(EXP_W_DEF);

    typedef struct packed {
        logic ovf;
        logic unf;
    } flags_t;

    localparam int unsigned FLAGS_W = $bits(flags_t);

endpackage

// File: rtl/s_exp_bias_pipe_if.sv
// Handshake bundle for s_exp_bias_pipe.
//   input channel : in_valid_i, in_ready_o, sum_i, norm_inc_i
//   output channel: out_valid_o, out_ready_i, exp_o, ovf_o, unf_o
// Signal suffixes are relative to the pipeline; the pipeline uses 'slave',
// the surrounding producer/consumer uses 'master'.
interface s_exp_bias_pipe_if
    import s_exp_bias_pipe_pkg::*;
#(
    parameter int unsigned W_EXP = EXP_W_DEF,
    parameter int unsigned W_SUM = SUM_W_DEF
);

    logic             in_valid_i;
    logic             in_ready_o;
    logic [W_SUM-1:0] sum_i;
    logic             norm_inc_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [W_EXP-1:0] exp_o;
    logic             ovf_o;
    logic             unf_o;

    modport master (
        output in_valid_i, sum_i, norm_inc_i, out_ready_i,
        input  in_ready_o, out_valid_o, exp_o, ovf_o, unf_o
    );

    modport slave (
        input  in_valid_i, sum_i, norm_inc_i, out_ready_i,
        output in_ready_o, out_valid_o, exp_o, ovf_o, unf_o
    );

endinterface

// File: rtl/s_pipe_reg.sv
// Generic valid/ready register slice, full throughput.
//   clk, rst               : clock, synchronous active-high reset
//   in_valid_i/in_ready_o  : upstream handshake (in_ready_o is combinational)
//   data_i                 : upstream payload, W bits
//   out_valid_o/out_ready_i: downstream handshake
//   data_o                 : registered payload
module s_pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic         load;

    // Accept when empty or when the held item leaves this cycle.
    always_comb begin
        in_ready_o = ~valid_q | out_ready_i;
        load       = in_valid_i & in_ready_o;
        valid_d    = valid_q;
        data_d     = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign data_o      = data_q;

endmodule

// File: rtl/s_exp_bias_pipe.sv
// Exponent bias removal and saturation, 2-stage valid/ready pipeline.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : sum_i/norm_inc_i in, exp_o/ovf_o/unf_o out, valid/ready both sides
//   clr_i        : clears the sticky flags
//   ovf_sticky_o : set by any transferred overflow result until cleared
//   unf_sticky_o : set by any transferred underflow result until cleared
// Stage 1 holds the signed unbiased exponent; stage 2 holds the saturated
// result and its flags.
module s_exp_bias_pipe
    import s_exp_bias_pipe_pkg::*;
#(
    parameter int unsigned W_EXP = EXP_W_DEF,
    parameter int unsigned BIAS  = BIAS_DEF,
    parameter int unsigned W_SUM = SUM_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    s_exp_bias_pipe_if.slave     bus,
    input  logic                 clr_i,
    output logic                 ovf_sticky_o,
    output logic                 unf_sticky_o
);

    // Two extra bits: one for the +1 carry, one for the sign after -BIAS.
    localparam int unsigned W_E     = W_SUM + 2;
    localparam int unsigned W_S2    = W_EXP + FLAGS_W;
    localparam int unsigned EXP_TOP = exp_max(W_EXP);

    logic [W_E-1:0]   e_c;
    logic             s1_in_ready;
    logic             s1_valid;
    logic [W_E-1:0]   s1_data;
    logic             s2_in_ready;
    logic             s2_valid;
    logic [W_S2-1:0]  s2_in_c;
    logic [W_S2-1:0]  s2_data;
    logic [W_EXP-1:0] sat_exp_c;
    flags_t           sat_flags_c;
    flags_t           out_flags;
    logic             out_xfer;
    logic             ovf_sticky_q;
    logic             ovf_sticky_d;
    logic             unf_sticky_q;
    logic             unf_sticky_d;

    // Unbiased exponent; two's complement in W_E bits cannot wrap.
    assign e_c = W_E'(bus.sum_i) + W_E'(bus.norm_inc_i) - W_E'(BIAS);

    s_pipe_reg #(.W(W_E)) u_s1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (bus.in_valid_i),
        .in_ready_o  (s1_in_ready),
        .data_i      (e_c),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_in_ready),
        .data_o      (s1_data)
    );

    // Saturate: the all-ones code is reserved, so reaching it is overflow.
    always_comb begin
        sat_exp_c   = '0;
        sat_flags_c = '0;
        if (!s1_data[W_E-1] && (s1_data >= W_E'(EXP_TOP))) begin
            sat_exp_c       = '1;
            sat_flags_c.ovf = 1'b1;
        end else if (s1_data[W_E-1] || (s1_data == '0)) begin
            sat_flags_c.unf = 1'b1;
        end else begin
            sat_exp_c = s1_data[W_EXP-1:0];
        end
        s2_in_c = {sat_exp_c, sat_flags_c};
    end

    s_pipe_reg #(.W(W_S2)) u_s2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_in_ready),
        .data_i      (s2_in_c),
        .out_valid_o (s2_valid),
        .out_ready_i (bus.out_ready_i),
        .data_o      (s2_data)
    );

    // Handshakes are masked during reset so nothing transfers in that cycle.
    assign bus.in_ready_o  = s1_in_ready & ~rst;
    assign bus.out_valid_o = s2_valid & ~rst;
    assign bus.exp_o       = s2_data[W_S2-1 -: W_EXP];
    assign out_flags       = flags_t'(s2_data[FLAGS_W-1:0]);
    assign bus.ovf_o       = out_flags.ovf;
    assign bus.unf_o       = out_flags.unf;
    assign out_xfer        = bus.out_valid_o & bus.out_ready_i;

    // Sticky status: a flag leaving this cycle beats a simultaneous clear.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        unf_sticky_d = unf_sticky_q;
        if (clr_i) begin
            ovf_sticky_d = 1'b0;
            unf_sticky_d = 1'b0;
        end
        if (out_xfer && out_flags.ovf) begin
            ovf_sticky_d = 1'b1;
        end
        if (out_xfer && out_flags.unf) begin
            unf_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign ovf_sticky_o = ovf_sticky_q;
    assign unf_sticky_o = unf_sticky_q;

endmodule

// File: tb/tb_s_exp_bias_pipe.sv
// Self-checking bench for s_exp_bias_pipe (W_EXP=8, BIAS=127, W_SUM=10).
module tb_s_exp_bias_pipe;
    import s_exp_bias_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic ovf_st;
    logic unf_st;

    always #5 clk = ~clk;

    s_exp_bias_pipe_if #(.W_EXP(8), .W_SUM(10)) bus ();

    s_exp_bias_pipe #(.W_EXP(8), .BIAS(127), .W_SUM(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .clr_i        (clr),
        .ovf_sticky_o (ovf_st),
        .unf_sticky_o (unf_st)
    );

    typedef struct packed {
        logic [7:0] exp;
        logic       ovf;
        logic       unf;
    } res_t;

    typedef struct {
        int         sum;
        logic       inc;
        logic [7:0] exp;
        logic       ovf;
        logic       unf;
    } vec_t;

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic st_ovf_m;
    logic st_unf_m;
    logic obs_in_ready;
    logic obs_valid;
    res_t obs;
    logic prev_hold;
    res_t prev_res;

    // Reference: unbiased exponent in plain integers, then the range rules.
    function automatic res_t ref_model(input int sum, input int inc);
        int   e;
        res_t r;
        e = sum + inc - 127;
        r = '0;
        if (e >= 255) begin
            r.exp = 8'(EXP_ONES);
            r.ovf = 1'b1;
        end else if (e <= 0) begin
            r.unf = 1'b1;
        end else begin
            r.exp = 8'(e);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: drive, settle, observe/score, advance to just after the edge.
    task automatic cycle(input logic v, input int s, input logic n, input logic r, input logic c);
        res_t got;
        res_t want;
        bus.in_valid_i  = v;
        bus.sum_i       = 10'(s);
        bus.norm_inc_i  = n;
        bus.out_ready_i = r;
        clr             = c;
        #1;
        obs_in_ready = bus.in_ready_o;
        obs_valid    = bus.out_valid_o;
        got          = {bus.exp_o, bus.ovf_o, bus.unf_o};
        obs          = got;
        check("ovf_sticky", 32'(ovf_st), 32'(st_ovf_m));
        check("unf_sticky", 32'(unf_st), 32'(st_unf_m));
        if (prev_hold) begin
            check("hold_valid", 32'(obs_valid), 32'd1);
            check("hold_data", 32'(got), 32'(prev_res));
        end
        if (c) begin
            st_ovf_m = 1'b0;
            st_unf_m = 1'b0;
        end
        if (obs_valid && r) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_extra: unexpected output %0h", got);
            end else begin
                want = exp_q.pop_front();
                check("out_data", 32'(got), 32'(want));
                if (want.ovf) st_ovf_m = 1'b1;
                if (want.unf) st_unf_m = 1'b1;
            end
        end
        prev_hold = obs_valid && !r;
        prev_res  = got;
        if (v && obs_in_ready) exp_q.push_back(ref_model(s, int'(n)));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        bus.sum_i       = '0;
        bus.norm_inc_i  = 1'b0;
        clr             = 1'b0;
        rst             = 1'b1;
        #1;
        check("rst_no_xfer", 32'(bus.out_valid_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        st_ovf_m  = 1'b0;
        st_unf_m  = 1'b0;
        prev_hold = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_exp", 32'(bus.exp_o), 32'd0);
        check("rst_flags", 32'({bus.ovf_o, bus.unf_o}), 32'd0);
        check("rst_sticky", 32'({ovf_st, unf_st}), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        int   bp_sum[8];
        int   sent;
        logic v;
        int   s;
        logic n;
        logic pend;

        tbl[0] = '{254,  1'b0, 8'd127, 1'b0, 1'b0};
        tbl[1] = '{381,  1'b0, 8'd254, 1'b0, 1'b0};
        tbl[2] = '{381,  1'b1, 8'd255, 1'b1, 1'b0};
        tbl[3] = '{127,  1'b0, 8'd0,   1'b0, 1'b1};
        tbl[4] = '{127,  1'b1, 8'd1,   1'b0, 1'b0};
        tbl[5] = '{0,    1'b0, 8'd0,   1'b0, 1'b1};
        tbl[6] = '{1023, 1'b1, 8'd255, 1'b1, 1'b0};
        tbl[7] = '{128,  1'b0, 8'd1,   1'b0, 1'b0};
        tbl[8] = '{380,  1'b1, 8'd254, 1'b0, 1'b0};
        tbl[9] = '{0,    1'b1, 8'd0,   1'b0, 1'b1};

        do_reset();

        // Directed vectors: one item at a time, latency and single-cycle valid.
        foreach (tbl[i]) begin
            cycle(1'b1, tbl[i].sum, tbl[i].inc, 1'b1, 1'b0);
            check("tbl_accept", 32'(obs_in_ready), 32'd1);
            cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
            check("tbl_lat1", 32'(obs_valid), 32'd0);
            cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
            check("tbl_valid", 32'(obs_valid), 32'd1);
            check("tbl_exp", 32'(obs.exp), 32'(tbl[i].exp));
            check("tbl_ovf", 32'(obs.ovf), 32'(tbl[i].ovf));
            check("tbl_unf", 32'(obs.unf), 32'(tbl[i].unf));
            cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
            check("tbl_one_cycle", 32'(obs_valid), 32'd0);
        end

        // Clear coinciding with an overflow transfer: set wins.
        do_reset();
        cycle(1'b1, 381, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
        check("clr_set_wins", 32'(ovf_st), 32'd1);
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
        check("clr_alone", 32'(ovf_st), 32'd0);

        // Back-pressure: 8 back-to-back items, consumer stalls cycles 3..6.
        do_reset();
        bp_sum = '{254, 381, 127, 0, 700, 300, 129, 1000};
        sent = 0;
        for (int k = 0; k < 40 && sent < 8; k++) begin
            cycle(1'b1, bp_sum[sent], 1'(sent), !(k >= 3 && k <= 6), 1'b0);
            if (k >= 3 && k <= 6) check("bp_in_ready_low", 32'(obs_in_ready), 32'd0);
            if (obs_in_ready) sent++;
        end
        check("bp_sent", sent, 8);
        for (int k = 0; k < 6; k++) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("bp_drain", exp_q.size(), 0);

        // Reset with both stages full, then a fresh item.
        do_reset();
        cycle(1'b1, 300, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 310, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 320, 1'b0, 1'b0, 1'b0);
        check("full_in_ready", 32'(obs_in_ready), 32'd0);
        do_reset();
        cycle(1'b1, 254, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("post_rst_lat1", 32'(obs_valid), 32'd0);
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("post_rst_valid", 32'(obs_valid), 32'd1);
        check("post_rst_exp", 32'(obs.exp), 32'd127);

        // Random traffic against the reference model and sticky model.
        do_reset();
        pend = 1'b0;
        v = 1'b0;
        s = 0;
        n = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (!pend) begin
                v = ($urandom_range(0, 3) != 0);
                s = int'($urandom_range(0, 1023));
                n = 1'($urandom_range(0, 1));
            end
            cycle(v, s, n, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            pend = v && !obs_in_ready;
        end
        for (int k = 0; k < 8; k++) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("rand_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
